// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial wide adder: slice width, FSM state
// encoding and a helper that sizes the nibble index counter.
package serial_add_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a counter that must hold 0..n-1 (never narrower than one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// Optional macro SERIAL_ADD_CTRL_SUB_EN adds the 'sub' operand flag.
interface serial_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  import serial_add_ctrl_pkg::*;

  localparam int W = NIB_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADD_CTRL_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  // Operand source and result consumer side.
  modport master (
`ifdef SERIAL_ADD_CTRL_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  // Adder side.
  modport slave (
`ifdef SERIAL_ADD_CTRL_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/serial_add_ctrl_nibble_add4.sv
// Purely combinational 4-bit ripple-carry slice shared by every nibble of
// the wide addition.
module nibble_add4
  import serial_add_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] sum,
  output logic             co
);

  logic carry;

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned, which would infer a latch.
    sum   = '0;
    carry = ci;
    for (int i = 0; i < NIB_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Wide adder (NIB_W*NIBBLES bits) built by stepping one nibble_add4 slice
// over the operands, LSB nibble first, with the carry held between cycles.
// Optional macro SERIAL_ADD_CTRL_SUB_EN enables subtraction (a - b).
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  serial_add_ctrl_if.slave bus
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, b_q, sum_q;
  logic               carry_q, cout_q;
  logic [IDX_W-1:0]   idx_q;
  logic               last_nib;
  logic               in_ready_c, out_valid_c, busy_c;
  logic [NIB_W-1:0]   nib_a, nib_b, nib_sum;
  logic               nib_co;
`ifdef SERIAL_ADD_CTRL_SUB_EN
  logic               sub_q;
`endif

  assign last_nib = (idx_q == LAST_IDX);
  assign nib_a    = a_q[idx_q*NIB_W +: NIB_W];
`ifdef SERIAL_ADD_CTRL_SUB_EN
  assign nib_b    = b_q[idx_q*NIB_W +: NIB_W] ^ {NIB_W{sub_q}};
`else
  assign nib_b    = b_q[idx_q*NIB_W +: NIB_W];
`endif

  nibble_add4 u_slice (
    .a   (nib_a),
    .b   (nib_b),
    .ci  (carry_q),
    .sum (nib_sum),
    .co  (nib_co)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy_c = 1'b1;
        if (last_nib) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture at the handshake and one nibble of sum per RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
            // Two's-complement subtract: invert b and inject a carry of one.
            sub_q   <= bus.sub;
            carry_q <= bus.sub | bus.cin;
`else
            carry_q <= bus.cin;
`endif
          end
        end
        ST_RUN: begin
          sum_q[idx_q*NIB_W +: NIB_W] <= nib_sum;
          carry_q <= nib_co;
          idx_q   <= idx_q + 1'b1;
          if (last_nib) cout_q <= nib_co;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a transaction-level model of the
// expected handshake timing and W+1-bit sum is compared every cycle, plus
// directed vectors with literal expected results.
// Optional macro SERIAL_ADD_CTRL_SUB_EN enables the subtraction vectors.
module tb_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int TIMEOUT = 4 * NIBBLES + 20;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic chk_en   = 1'b0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Busy from the accepting edge; result presented NIBBLES edges later;
  // idle again on the edge the result is taken.
  logic         m_busy, m_valid, m_cout;
  logic [W-1:0] m_sum;
  int           m_cnt;

  function automatic logic [W:0] model_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic cin, input logic sub);
    logic [W-1:0] eb;
    logic         ec;
    eb = sub ? ~b : b;
    ec = sub ? 1'b1 : cin;
    return {1'b0, a} + {1'b0, eb} + {{W{1'b0}}, ec};
  endfunction

  logic tb_sub;
`ifdef SERIAL_ADD_CTRL_SUB_EN
  assign tb_sub = bus.sub;
`else
  assign tb_sub = 1'b0;
`endif

  always @(posedge clk) begin
    if (reset) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_cnt   <= 0;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        m_busy            <= 1'b1;
        m_cnt             <= 0;
        {m_cout, m_sum}   <= model_result(bus.a, bus.b, bus.cin, tb_sub);
      end
    end else if (!m_valid) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == NIBBLES - 1) m_valid <= 1'b1;
    end else if (bus.out_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  // Compare process: handshake flags every cycle, sum/cout whenever stable.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("in_ready", bus.in_ready, !m_busy);
      check("out_valid", bus.out_valid, m_valid);
      check("busy", bus.busy, m_busy);
      if (!m_busy || m_valid) begin
        check("sum", bus.sum, m_sum);
        check("cout", bus.cout, m_cout);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub);
    int n = 0;
    while (!bus.in_ready && n < TIMEOUT) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 1'b0, 1'b1);
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    bus.sub = sub;
`else
    if (sub) check("sub_unsupported", 1'b1, 1'b0);
`endif
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < TIMEOUT) begin
      tick();
      cycles++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 1'b0, 1'b1);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] sum, input logic cout);
    check({name, "_sum"}, bus.sum, sum);
    check({name, "_cout"}, bus.cout, cout);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int cyc;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    bus.sub       = 1'b0;
`endif
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 1'b0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Simple add, latency and in_ready low while busy.
    start_op(16'h0003, 16'h0004, 1'b0, 1'b0);
    check("t1_in_ready_low", bus.in_ready, 1'b0);
    check("t1_busy", bus.busy, 1'b1);
    wait_result(cyc);
    check("t1_latency", cyc, NIBBLES);
    expect_result("t1", 16'h0007, 1'b0);
    check("t1_in_ready_done", bus.in_ready, 1'b0);
    take();
    check("t1_back_idle", bus.in_ready, 1'b1);

    // Carry ripples through every nibble.
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_result(cyc);
    expect_result("t2", 16'h0000, 1'b1);
    take();

    // Inputs scrambled after acceptance must not matter.
    start_op(16'h1234, 16'hABCD, 1'b1, 1'b0);
    cyc = 0;
    while (!bus.out_valid && cyc < TIMEOUT) begin
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.cin = 1'($urandom);
      tick();
      cyc++;
    end
    expect_result("t3", 16'hBE02, 1'b0);
    take();

    // Backpressure with in_valid held high throughout.
    start_op(16'h000A, 16'h000F, 1'b0, 1'b0);
    wait_result(cyc);
    bus.a = 16'h0001;
    bus.b = 16'h0001;
    bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", bus.out_valid, 1'b1);
      check("t4_hold_in_ready", bus.in_ready, 1'b0);
      expect_result("t4_hold", 16'h0019, 1'b0);
    end
    take();
    check("t4_idle_in_ready", bus.in_ready, 1'b1);
    check("t4_idle_busy", bus.busy, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("t4_reaccept_busy", bus.busy, 1'b1);
    wait_result(cyc);
    expect_result("t4_next", 16'h0002, 1'b0);
    take();

    // Reset in the middle of RUN (idx = 2).
    start_op(16'h8888, 16'h8888, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_in_ready", bus.in_ready, 1'b1);
    check("t5_out_valid", bus.out_valid, 1'b0);
    check("t5_busy", bus.busy, 1'b0);
    expect_result("t5_rst", 16'h0000, 1'b0);
    start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_result(cyc);
    expect_result("t5_after", 16'h0002, 1'b0);
    take();

`ifdef SERIAL_ADD_CTRL_SUB_EN
    // Subtraction with and without borrow; cin ignored when subtracting.
    start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_result(cyc);
    expect_result("t6_borrow", 16'hFFFE, 1'b0);
    take();
    start_op(16'h0007, 16'h0005, 1'b0, 1'b1);
    wait_result(cyc);
    expect_result("t6_noborrow", 16'h0002, 1'b1);
    take();
`endif

    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that performs wide additions (4*NIBBLES bits) by time-multiplexing a single 4-bit ripple-carry slice, one nibble per cycle, LSB first.
- Latches the carry between cycles and exposes valid/ready handshakes on both the operand side and the result side.
- Sits between an operand source (register file / stimulus FSM) and any consumer of wide sums.
- Trades area for latency against a fully parallel wide adder.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and cin are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry into nibble 0.
- out_valid  output  1  sum/cout valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  result.
- cout  output  1  carry out of the top nibble.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: one clk edge with reset=1 forces state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, nibble index=0, carry register=0. Reset has priority over every other event, including mid-RUN and mid-DONE; a partial result is discarded without being presented.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready at edge T:
  - latch a, b and cin into the operand and carry registers;
  - clear sum, idx=0;
  - go to RUN.
- RUN: one nibble per edge.
  - Each edge: sum[4*idx+:4] <= slice sum of a[4*idx+:4], b[4*idx+:4] and the carry register; carry register <= slice carry-out; idx++.
  - After the edge that processes idx=NIBBLES-1: cout <= final carry and the FSM goes to DONE.
  - in_ready=0 throughout; in_valid is ignored.
- Latency: handshake at edge T; out_valid=1 is first visible in the cycle after edge T+NIBBLES. Example: NIBBLES=4 gives 4 RUN edges.
- DONE: out_valid=1; sum and cout are stable.
  - On out_valid&&out_ready: go to IDLE, out_valid=0, in_ready=1 in the next cycle.
  - No same-cycle re-accept: a new operand cannot be accepted on the edge the result is taken. Throughput is one operation per NIBBLES+2 cycles minimum.
- Backpressure: out_ready may stay low indefinitely; all outputs hold.
- Width rules: W-bit modular sum. {cout,sum} == a+b+cin exactly (W+1 bits).
- Operands are registered at the handshake. Changes to a, b or cin after acceptance have no effect.
- NIBBLES=1: a single RUN cycle; identical to one 4-bit add with registered result.

Optional Feature:
- Macro: SERIAL_ADD_CTRL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched at the handshake.
  - When sub=1: B is inverted nibble-wise and the initial carry is forced to 1 (cin ignored). Result = a-b mod 2^W; cout=1 means no borrow (a>=b unsigned).
  - When sub=0: behaviour identical to the undefined case.
- Undefined: no sub port; addition only.

Decomposition:
- Shared include serial_add_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - slice width constant NIB_W=4.
- One natural sub-module: nibble_add4. It is a purely combinational 4-bit ripple slice (sum[3:0], co from a[3:0], b[3:0], ci), instanced once.
- The controller owns the FSM, the index counter, the carry register and the operand/result registers.

Test Plan:
- NIBBLES=4, a=0x0003, b=0x0004, cin=0 -> after 4 RUN edges out_valid=1, sum=0x0007, cout=0; in_ready low from handshake until result accepted.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; the carry propagates across all 4 nibbles.
- a=0x1234, b=0xABCD, cin=1 -> sum=0xBE02, cout=0. Drive a, b and cin to random values during RUN; the result must be unchanged.
- Backpressure: a=0x000A, b=0x000F; hold out_ready=0 for 5 cycles -> sum=0x0019, cout=0, out_valid steady; in_valid=1 asserted throughout is not accepted. A new operation is accepted only after the out handshake and a return to IDLE.
- Reset mid-operation: assert reset for 1 cycle at RUN idx=2 (a=0x8888, b=0x8888) -> next cycle IDLE, out_valid=0, sum=0, cout=0, in_ready=1. A following add of 0x0001+0x0001 gives 0x0002, cout=0, with no stale carry.
- With SERIAL_ADD_CTRL_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. Then a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
